down_timer: RTL and testbench
=============================

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter: W, 4, counter and load-data width in bits (W >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: l  input  1  load control; sampled at posedge clk.
REQ-005 SHALL have port: i  input  W  value to be loaded when l=1.
REQ-006 SHALL have port: c  input  1  count-down enable.
REQ-007 SHALL have port: a  input  1  auto-reload enable; sampled on the terminal decrement only.
REQ-008 SHALL have port: r  output  W  current count, registered.
REQ-009 SHALL have port: z  output  1  r == 0, combinational from r.
REQ-010 SHALL have port: busy  output  1  state == RUN, combinational from state.
REQ-011 SHALL have port: done  output  1  registered one-cycle expiry pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, plus a W-bit reload register rld.
REQ-013 SHALL take priority per cycle as: rst_n low, then l, then c; load and count never both act in one cycle.
REQ-014 SHALL, on l=1 in any state with i != 0: r <= i, rld <= i, state <= RUN.
REQ-015 SHALL, on l=1 in any state with i == 0: r <= 0, rld <= 0, state <= IDLE, with no done pulse.
REQ-016 SHALL, in RUN with l=0, c=1 and r > 1: r <= r - 1, state stays RUN.
REQ-017 SHALL, in RUN with l=0, c=1 and r == 1 (terminal decrement): done <= 1 in the next cycle.
REQ-018 SHALL, on a terminal decrement with a=1: r <= rld and stay in RUN (periodic mode, no cycle at r=0).
REQ-019 SHALL, on a terminal decrement with a=0: r <= 0 and state <= DONE.
REQ-020 SHALL hold r and state in RUN when l=0 and c=0 (pause).
REQ-021 SHALL hold r = 0 in IDLE and DONE regardless of c and a; only l or reset leaves these states.
REQ-022 SHALL drive done high for exactly one cycle per terminal decrement, and low in every other cycle.
REQ-023 SHALL not allow r to underflow; the count in RUN is always >= 1, so no modulo wrap occurs.
REQ-024 SHALL, on l=1 coincident with a terminal decrement, perform the load and emit no done pulse.
REQ-025 SHALL, in RUN with l=1 and i != 0, restart from i while discarding the remaining count.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, r=0, rld=0, done=0, independent of clk.
REQ-027 SHALL abort any count when rst_n is asserted mid-RUN, with no done pulse.
REQ-028 SHALL resume normal operation on the first posedge clk after rst_n deasserts.
REQ-029 SHALL present z=1 and busy=0 out of reset.

Verification
REQ-030 SHALL cover one-shot expiry: reset, load i=3, c=1, a=0 -> r: 3,2,1,0; done high one cycle at r=0; state DONE; z=1, busy=0.
REQ-031 SHALL cover auto-reload: load i=2, c=1, a=1 -> r: 2,1,2,1,2...; done pulses every 2 cycles; busy stays 1.
REQ-032 SHALL cover pause and priority: load 5, count to 3, drop c for 4 cycles -> r holds 3; then assert l=1, c=1, i=9 -> r=9 with no decrement.
REQ-033 SHALL cover load-at-terminal: r=1, c=1, l=1, i=6 -> r=6, state RUN, done stays 0.
REQ-034 SHALL cover zero load: in RUN, load i=0 -> r=0, state IDLE, done=0; c=1 afterwards leaves r=0.
REQ-035 SHALL cover async reset: in RUN at r=4, pulse rst_n low between clock edges -> r=0, busy=0 immediately, no done pulse, rld=0.

Source files
------------

// File: rtl/down_timer.sv
// Down-counting timer with load, pause, one-shot and auto-reload modes.
// A non-zero load starts a run; the terminal decrement (r == 1) either
// reloads from the last loaded value (a=1) or parks at zero (a=0), and in
// both cases raises a registered one-cycle done pulse.
module down_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         l,
  input  logic [W-1:0] i,
  input  logic         c,
  input  logic         a,
  output logic [W-1:0] r,
  output logic         z,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  state_t       state_q, state_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] rld_q, rld_d;
  logic         done_q, done_d;

  // Next-state logic: load beats count; counting only happens in RUN.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (l) begin
      // A zero load is treated as a cancel: back to IDLE without a pulse.
      if (i != ZERO) begin
        r_d     = i;
        rld_d   = i;
        state_d = RUN;
      end else begin
        r_d     = ZERO;
        rld_d   = ZERO;
        state_d = IDLE;
      end
    end else if ((state_q == RUN) && c) begin
      if (r_q > ONE) begin
        r_d = r_q - ONE;
      end else begin
        // Terminal decrement: the count never reaches zero while in RUN
        // in periodic mode, so there is no wrap and no idle cycle.
        done_d = 1'b1;
        if (a) begin
          r_d = rld_q;
        end else begin
          r_d     = ZERO;
          state_d = DONE;
        end
      end
    end
  end

  // State, count, reload value and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= ZERO;
      rld_q   <= ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  assign r    = r_q;
  assign z    = (r_q == ZERO);
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (W=4): reset, one-shot, auto-reload,
// pause/priority, load at terminal, zero load, boundary loads, async reset.
module tb_down_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         l;
  logic [W-1:0] i;
  logic         c;
  logic         a;
  logic [W-1:0] r;
  logic         z;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  down_timer #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .l    (l),
    .i    (i),
    .c    (c),
    .a    (a),
    .r    (r),
    .z    (z),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; l = 1'b0; i = '0; c = 1'b0; a = 1'b0;
    #12;
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", r); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL reset_z got=%b exp=1", z); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (r !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle r=%0d busy=%b exp r=0 busy=0", r, busy); end
  endtask

  task automatic test_oneshot();
    l = 1'b1; i = 4'd3; c = 1'b1; a = 1'b0;
    step();
    checks++; if (r !== 4'd3 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL oneshot_load r=%0d busy=%b done=%b exp 3/1/0", r, busy, done); end
    l = 1'b0;
    step();
    checks++; if (r !== 4'd2 || done !== 1'b0) begin errors++; $display("FAIL oneshot_r2 r=%0d done=%b exp 2/0", r, done); end
    step();
    checks++; if (r !== 4'd1 || done !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL oneshot_r1 r=%0d done=%b z=%b exp 1/0/0", r, done, z); end
    step();
    checks++; if (r !== 4'd0 || done !== 1'b1 || z !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL oneshot_expire r=%0d done=%b z=%b busy=%b exp 0/1/1/0", r, done, z, busy); end
    a = 1'b1;
    step();
    checks++; if (r !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL oneshot_after r=%0d done=%b busy=%b exp 0/0/0", r, done, busy); end
    step();
    checks++; if (r !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_hold r=%0d done=%b busy=%b exp 0/0/0", r, done, busy); end
  endtask

  task automatic test_autoreload();
    logic [W-1:0] exp_r [6];
    logic         exp_d [6];
    exp_r = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    l = 1'b1; i = 4'd2; c = 1'b1; a = 1'b1;
    step();
    checks++; if (r !== 4'd2 || busy !== 1'b1) begin errors++; $display("FAIL auto_load r=%0d busy=%b exp 2/1", r, busy); end
    l = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (r !== exp_r[k] || done !== exp_d[k] || busy !== 1'b1) begin
        errors++;
        $display("FAIL auto_cycle%0d r=%0d done=%b busy=%b exp %0d/%b/1", k, r, done, busy, exp_r[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_pause_priority();
    l = 1'b1; i = 4'd5; c = 1'b1; a = 1'b0;
    step();
    l = 1'b0;
    step();
    step();
    checks++; if (r !== 4'd3) begin errors++; $display("FAIL pause_pre r=%0d exp=3", r); end
    c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (r !== 4'd3 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold%0d r=%0d busy=%b done=%b exp 3/1/0", k, r, busy, done);
      end
    end
    l = 1'b1; c = 1'b1; i = 4'd9;
    step();
    checks++; if (r !== 4'd9 || busy !== 1'b1) begin errors++; $display("FAIL prio_load r=%0d busy=%b exp 9/1", r, busy); end
    l = 1'b0;
    step();
    checks++; if (r !== 4'd8) begin errors++; $display("FAIL prio_count r=%0d exp=8", r); end
  endtask

  task automatic test_load_terminal();
    l = 1'b1; i = 4'd2; c = 1'b1; a = 1'b0;
    step();
    l = 1'b0;
    step();
    checks++; if (r !== 4'd1) begin errors++; $display("FAIL term_pre r=%0d exp=1", r); end
    l = 1'b1; i = 4'd6;
    step();
    checks++; if (r !== 4'd6 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL term_load r=%0d busy=%b done=%b exp 6/1/0", r, busy, done); end
    l = 1'b0;
    step();
    checks++; if (r !== 4'd5 || done !== 1'b0) begin errors++; $display("FAIL term_next r=%0d done=%b exp 5/0", r, done); end
  endtask

  task automatic test_zero_load();
    l = 1'b1; i = 4'd0; c = 1'b1; a = 1'b1;
    step();
    checks++; if (r !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL zero_load r=%0d busy=%b done=%b z=%b exp 0/0/0/1", r, busy, done, z); end
    l = 1'b0;
    step();
    checks++; if (r !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_hold r=%0d busy=%b done=%b exp 0/0/0", r, busy, done); end
  endtask

  task automatic test_boundary_loads();
    l = 1'b1; i = 4'd15; c = 1'b0; a = 1'b0;
    step();
    checks++; if (r !== 4'd15 || z !== 1'b0) begin errors++; $display("FAIL max_load r=%0d z=%b exp 15/0", r, z); end
    l = 1'b1; i = 4'd1; c = 1'b1;
    step();
    checks++; if (r !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL one_load r=%0d busy=%b exp 1/1", r, busy); end
    l = 1'b0;
    step();
    checks++; if (r !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL one_expire r=%0d done=%b busy=%b exp 0/1/0", r, done, busy); end
  endtask

  task automatic test_async_reset();
    l = 1'b1; i = 4'd6; c = 1'b1; a = 1'b1;
    step();
    l = 1'b0;
    step();
    step();
    checks++; if (r !== 4'd4) begin errors++; $display("FAIL areset_pre r=%0d exp=4", r); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (r !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_now r=%0d busy=%b done=%b exp 0/0/0", r, busy, done); end
    checks++; if (dut.rld_q !== 4'd0) begin errors++; $display("FAIL areset_rld got=%0d exp=0", dut.rld_q); end
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (r !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_after r=%0d busy=%b done=%b exp 0/0/0", r, busy, done); end
    l = 1'b1; i = 4'd2; c = 1'b1; a = 1'b0;
    step();
    checks++; if (r !== 4'd2 || busy !== 1'b1) begin errors++; $display("FAIL areset_resume r=%0d busy=%b exp 2/1", r, busy); end
    l = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause_priority();
    test_load_terminal();
    test_zero_load();
    test_boundary_loads();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
